// File: rtl/phy_tx_lane_serializer_pkg.sv
// Shared definitions for the phy_tx lane serializer.
//   state_e     : serializer FSM states (alignment preamble, then normal traffic)
//   DEFAULT_COM : 8-bit idle/alignment symbol used when no other COM is given
package phy_tx_lane_serializer_pkg;

  // SYNC sends the forced COM preamble after reset; RUN accepts link-layer words
  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [7:0] DEFAULT_COM = 8'hBC;

endpackage

// File: rtl/phy_tx_lane_shift.sv
// One lane of the transmit serializer: a WIDTH-bit shift register.
//   clk_i       : bit clock
//   rst_ni      : synchronous reset, active low (clears the register)
//   load_i      : capture sym_i this edge (takes priority over shift_i)
//   shift_i     : advance one bit this edge
//   msb_first_i : 1 shifts towards the MSB end, 0 towards the LSB end
//   sym_i       : symbol to load
//   bit_o       : bit currently presented on the lane (direct flop output)
module phy_tx_lane_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             msb_first_i,
  input  logic [WIDTH-1:0] sym_i,
  output logic             bit_o
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next register contents: a freshly loaded symbol already presents its first
  // bit at the output end, so each shift exposes the following bit in order.
  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = sym_i;
    end else if (shift_i) begin
      if (msb_first_i) begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
    end
  end

  // Shift register state; reset discards any partly sent symbol
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign bit_o = msb_first_i ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/phy_tx_lane_serializer.sv
// Multi-lane PHY transmit serializer on a single bit clock.
// Takes one WIDTH-bit word per lane per symbol period through valid/ready and
// shifts it out one bit per cycle per lane. COM is inserted whenever no word is
// offered, and SYNC_COMS COM symbols are sent after every reset before ready can rise.
//   dclk           : bit clock, every register uses its rising edge
//   default_values : synchronous reset, active low
//   valid          : data_in holds one word per lane
//   data_in        : lane i word = data_in[i*WIDTH +: WIDTH]
//   ready          : a word is taken this cycle when valid is also high
//   data_out       : serial bit per lane, registered
//   cnt            : index of the bit currently on data_out
//   sym_is_com     : symbol currently on data_out is an inserted COM
module phy_tx_lane_serializer
  import phy_tx_lane_serializer_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               LANES     = 1,
  parameter logic [WIDTH-1:0] COM       = WIDTH'(DEFAULT_COM),
  parameter int               SYNC_COMS = 4,
  parameter int               MSB_FIRST = 1
) (
  input  logic                     dclk,
  input  logic                     default_values,
  input  logic                     valid,
  input  logic [LANES*WIDTH-1:0]   data_in,
  output logic                     ready,
  output logic [LANES-1:0]         data_out,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     sym_is_com
);

  localparam int             CW        = $clog2(WIDTH);
  localparam int             SW        = $clog2(SYNC_COMS + 1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [SW-1:0]  SYNC_LAST = SW'(SYNC_COMS);

  state_e                 state_q;
  state_e                 state_d;
  logic [SW-1:0]          sync_q;
  logic [SW-1:0]          sync_d;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   com_q;
  logic                   com_d;
  logic                   boundary;
  logic                   take;
  logic [LANES*WIDTH-1:0] lane_sym;

  // A boundary edge is the one that retires the last bit of the current symbol
  assign boundary = (cnt_q == CNT_LAST);

  // Ready only exists in RUN and only at the boundary, so all lanes stay aligned
  assign ready = default_values && boundary && (state_q == ST_RUN);
  assign take  = valid && ready;

  // Next-state logic: bit counter, preamble counter, FSM and the symbol each lane
  // loads at the boundary. COM is the default load so lanes never go silent.
  always_comb begin
    state_d  = state_q;
    sync_d   = sync_q;
    com_d    = com_q;
    cnt_d    = cnt_q + 1'b1;
    lane_sym = {LANES{COM}};
    if (boundary) begin
      cnt_d = '0;
      if (state_q == ST_SYNC) begin
        com_d  = 1'b1;
        sync_d = sync_q + 1'b1;
        if ((sync_q + 1'b1) == SYNC_LAST) begin
          state_d = ST_RUN;
        end
      end else if (take) begin
        com_d    = 1'b0;
        lane_sym = data_in;
      end else begin
        com_d = 1'b1;
      end
    end
  end

  // Control registers; reset restarts the preamble with cnt parked at the last
  // bit so the first edge after release is a boundary
  always_ff @(posedge dclk) begin
    if (!default_values) begin
      state_q <= ST_SYNC;
      sync_q  <= '0;
      cnt_q   <= CNT_LAST;
      com_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      com_q   <= com_d;
    end
  end

  // One shift register per lane, all driven by the shared bit counter
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    phy_tx_lane_shift #(
      .WIDTH(WIDTH)
    ) u_shift (
      .clk_i      (dclk),
      .rst_ni     (default_values),
      .load_i     (boundary),
      .shift_i    (!boundary),
      .msb_first_i(MSB_FIRST != 0),
      .sym_i      (lane_sym[i*WIDTH +: WIDTH]),
      .bit_o      (data_out[i])
    );
  end

  assign cnt        = cnt_q;
  assign sym_is_com = com_q;

endmodule

// File: tb/tb_phy_tx_lane_serializer.sv
// Directed testbench for phy_tx_lane_serializer.
// dutA: WIDTH=8, LANES=2, SYNC_COMS=2, MSB_FIRST=1, COM=8'hBC
// dutB: WIDTH=10, LANES=1, SYNC_COMS=2, MSB_FIRST=0, COM=10'h17C
module tb_phy_tx_lane_serializer;

  logic        clk = 1'b0;

  logic        rstA;
  logic        validA;
  logic [15:0] dataA;
  logic        readyA;
  logic [1:0]  doutA;
  logic [2:0]  cntA;
  logic        comA;

  logic        rstB;
  logic        validB;
  logic [9:0]  dataB;
  logic        readyB;
  logic [0:0]  doutB;
  logic [3:0]  cntB;
  logic        comB;

  int checks = 0;
  int fails  = 0;

  // Free-running bit clock shared by both instances
  always #5 clk = ~clk;

  phy_tx_lane_serializer #(
    .WIDTH(8), .LANES(2), .COM(8'hBC), .SYNC_COMS(2), .MSB_FIRST(1)
  ) dutA (
    .dclk(clk), .default_values(rstA), .valid(validA), .data_in(dataA),
    .ready(readyA), .data_out(doutA), .cnt(cntA), .sym_is_com(comA)
  );

  phy_tx_lane_serializer #(
    .WIDTH(10), .LANES(1), .COM(10'h17C), .SYNC_COMS(2), .MSB_FIRST(0)
  ) dutB (
    .dclk(clk), .default_values(rstB), .valid(validB), .data_in(dataB),
    .ready(readyB), .data_out(doutB), .cnt(cntB), .sym_is_com(comB)
  );

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held: outputs at their defaults, ready low
  task automatic test_reset();
    rstA = 1'b0;
    validA = 1'b0;
    repeat (3) tick();
    checks++; if (doutA !== 2'b00) begin fails++; $display("[TB] FAIL reset dout: got %b expected 00", doutA); end
    checks++; if (cntA !== 3'd7) begin fails++; $display("[TB] FAIL reset cnt: got %0d expected 7", cntA); end
    checks++; if (comA !== 1'b0) begin fails++; $display("[TB] FAIL reset sym_is_com: got %b expected 0", comA); end
    checks++; if (readyA !== 1'b0) begin fails++; $display("[TB] FAIL reset ready: got %b expected 0", readyA); end
    rstA = 1'b1;
    checks++; if (readyA !== 1'b0) begin fails++; $display("[TB] FAIL release ready: got %b expected 0", readyA); end
  endtask

  // 24 edges after release with valid low: continuous COM, ready first after edge 16
  task automatic test_sync();
    logic [7:0] comv;
    logic       b;
    logic       expRdy;
    int         c;
    comv = 8'hBC;
    for (int e = 1; e <= 24; e++) begin
      tick();
      c = (e - 1) % 8;
      b = comv[7 - c];
      expRdy = (e == 16) || (e == 24);
      checks++; if (cntA !== 3'(c)) begin fails++; $display("[TB] FAIL sync cnt e=%0d: got %0d expected %0d", e, cntA, c); end
      checks++; if (doutA !== {b, b}) begin fails++; $display("[TB] FAIL sync dout e=%0d: got %b expected %b%b", e, doutA, b, b); end
      checks++; if (comA !== 1'b1) begin fails++; $display("[TB] FAIL sync sym_is_com e=%0d: got %b expected 1", e, comA); end
      checks++; if (readyA !== expRdy) begin fails++; $display("[TB] FAIL sync ready e=%0d: got %b expected %b", e, readyA, expRdy); end
    end
  endtask

  // One word per lane, MSB first, first bit right after the accepting edge
  task automatic test_data();
    logic [7:0] w1;
    logic [7:0] w0;
    int n;
    w1 = 8'hA5;
    w0 = 8'h3C;
    validA = 1'b1;
    dataA = {w1, w0};
    n = 0;
    while (!readyA && n < 20) begin
      tick();
      n++;
    end
    checks++; if (readyA !== 1'b1) begin fails++; $display("[TB] FAIL data wait ready: got %b expected 1 within 20 cycles", readyA); end
    tick();
    validA = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++; if (cntA !== 3'(k)) begin fails++; $display("[TB] FAIL data cnt k=%0d: got %0d expected %0d", k, cntA, k); end
      checks++; if (doutA !== {w1[7 - k], w0[7 - k]}) begin fails++; $display("[TB] FAIL data dout k=%0d: got %b expected %b%b", k, doutA, w1[7 - k], w0[7 - k]); end
      checks++; if (comA !== 1'b0) begin fails++; $display("[TB] FAIL data sym_is_com k=%0d: got %b expected 0", k, comA); end
      checks++; if (readyA !== (k == 7)) begin fails++; $display("[TB] FAIL data ready k=%0d: got %b expected %b", k, readyA, (k == 7)); end
      if (k < 7) tick();
    end
  endtask

  // Two words back to back with valid held: 16 contiguous bits, ready every 8 cycles
  task automatic test_back_to_back();
    logic [15:0] seq0;
    logic [15:0] seq1;
    seq0 = 16'h0102;
    seq1 = 16'hF00F;
    validA = 1'b1;
    dataA = {8'hF0, 8'h01};
    tick();
    for (int i = 0; i < 16; i++) begin
      checks++; if (cntA !== 3'(i % 8)) begin fails++; $display("[TB] FAIL b2b cnt i=%0d: got %0d expected %0d", i, cntA, i % 8); end
      checks++; if (doutA !== {seq1[15 - i], seq0[15 - i]}) begin fails++; $display("[TB] FAIL b2b dout i=%0d: got %b expected %b%b", i, doutA, seq1[15 - i], seq0[15 - i]); end
      checks++; if (comA !== 1'b0) begin fails++; $display("[TB] FAIL b2b sym_is_com i=%0d: got %b expected 0", i, comA); end
      checks++; if (readyA !== ((i % 8) == 7)) begin fails++; $display("[TB] FAIL b2b ready i=%0d: got %b expected %b", i, readyA, ((i % 8) == 7)); end
      if (i == 0) dataA = {8'h0F, 8'h02};
      if (i == 8) validA = 1'b0;
      tick();
    end
  endtask

  // valid dropped: COM inserted on both lanes; data_in churn is ignored
  task automatic test_idle();
    logic [7:0] comv;
    logic       b;
    comv = 8'hBC;
    for (int k = 0; k < 8; k++) begin
      dataA = 16'h5A00 + 16'(k * 17);
      b = comv[7 - k];
      checks++; if (cntA !== 3'(k)) begin fails++; $display("[TB] FAIL idle cnt k=%0d: got %0d expected %0d", k, cntA, k); end
      checks++; if (doutA !== {b, b}) begin fails++; $display("[TB] FAIL idle dout k=%0d: got %b expected %b%b", k, doutA, b, b); end
      checks++; if (comA !== 1'b1) begin fails++; $display("[TB] FAIL idle sym_is_com k=%0d: got %b expected 1", k, comA); end
      checks++; if (readyA !== (k == 7)) begin fails++; $display("[TB] FAIL idle ready k=%0d: got %b expected %b", k, readyA, (k == 7)); end
      if (k < 7) tick();
    end
  endtask

  // Reset in the middle of a data symbol drops it and restarts sync
  task automatic test_reset_mid();
    checks++; if (readyA !== 1'b1) begin fails++; $display("[TB] FAIL midrst precondition ready: got %b expected 1", readyA); end
    validA = 1'b1;
    dataA = {8'hA5, 8'h3C};
    tick();
    validA = 1'b0;
    repeat (3) tick();
    checks++; if (cntA !== 3'd3) begin fails++; $display("[TB] FAIL midrst cnt before: got %0d expected 3", cntA); end
    checks++; if (comA !== 1'b0) begin fails++; $display("[TB] FAIL midrst sym_is_com before: got %b expected 0", comA); end
    rstA = 1'b0;
    tick();
    checks++; if (doutA !== 2'b00) begin fails++; $display("[TB] FAIL midrst dout: got %b expected 00", doutA); end
    checks++; if (cntA !== 3'd7) begin fails++; $display("[TB] FAIL midrst cnt: got %0d expected 7", cntA); end
    checks++; if (readyA !== 1'b0) begin fails++; $display("[TB] FAIL midrst ready: got %b expected 0", readyA); end
    checks++; if (comA !== 1'b0) begin fails++; $display("[TB] FAIL midrst sym_is_com: got %b expected 0", comA); end
    rstA = 1'b1;
    checks++; if (readyA !== 1'b0) begin fails++; $display("[TB] FAIL midrst release ready: got %b expected 0", readyA); end
  endtask

  // WIDTH=10, LSB first: COM pattern, cnt wrap 9 -> 0, then one data word
  task automatic test_width10();
    logic [9:0] comv;
    logic       expRdy;
    int         c;
    comv = 10'h17C;
    rstB = 1'b0;
    validB = 1'b0;
    tick();
    checks++; if (cntB !== 4'd9) begin fails++; $display("[TB] FAIL w10 reset cnt: got %0d expected 9", cntB); end
    checks++; if (doutB !== 1'b0) begin fails++; $display("[TB] FAIL w10 reset dout: got %b expected 0", doutB); end
    rstB = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      c = (e - 1) % 10;
      expRdy = (e == 20);
      checks++; if (cntB !== 4'(c)) begin fails++; $display("[TB] FAIL w10 sync cnt e=%0d: got %0d expected %0d", e, cntB, c); end
      checks++; if (doutB !== comv[c]) begin fails++; $display("[TB] FAIL w10 sync dout e=%0d: got %b expected %b", e, doutB, comv[c]); end
      checks++; if (comB !== 1'b1) begin fails++; $display("[TB] FAIL w10 sync sym_is_com e=%0d: got %b expected 1", e, comB); end
      checks++; if (readyB !== expRdy) begin fails++; $display("[TB] FAIL w10 sync ready e=%0d: got %b expected %b", e, readyB, expRdy); end
    end
    validB = 1'b1;
    dataB = 10'h001;
    tick();
    validB = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++; if (cntB !== 4'(k)) begin fails++; $display("[TB] FAIL w10 data cnt k=%0d: got %0d expected %0d", k, cntB, k); end
      checks++; if (doutB !== (k == 0)) begin fails++; $display("[TB] FAIL w10 data dout k=%0d: got %b expected %b", k, doutB, (k == 0)); end
      checks++; if (comB !== 1'b0) begin fails++; $display("[TB] FAIL w10 data sym_is_com k=%0d: got %b expected 0", k, comB); end
      if (k < 9) tick();
    end
  endtask

  // Scenario sequence; dutB stays in reset until its own test
  initial begin
    rstA = 1'b0;
    validA = 1'b0;
    dataA = '0;
    rstB = 1'b0;
    validB = 1'b0;
    dataB = '0;
    $display("[TB] starting phy_tx_lane_serializer tests");
    test_reset();
    test_sync();
    test_data();
    test_back_to_back();
    test_idle();
    test_reset_mid();
    test_sync();
    test_width10();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
